// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH flip-flops with a shared run-time mode (D/T/SR/JK) and
// illegal-SR detection with a pulse, a sticky flag and a saturating counter.

module multimode_ff_lane #(
  parameter int       SR_POLICY = 0,
  parameter bit       RESET_BIT = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  input  logic       i_a,
  input  logic       i_b,
  output logic       o_q,
  output logic       o_qn
);
  logic r_q, r_qn, w_nxt, w_sr11;

  // Resolution of S=R=1; always a defined value, never X.
  always_comb begin
    w_sr11 = r_q;
    case (SR_POLICY)
      1:       w_sr11 = 1'b0;
      2:       w_sr11 = 1'b1;
      default: w_sr11 = r_q;
    endcase
  end

  always_comb begin
    w_nxt = r_q;
    case (i_mode)
      2'b00: w_nxt = i_a;
      2'b01: w_nxt = r_q ^ i_a;
      2'b10: case ({i_a, i_b})
               2'b01:   w_nxt = 1'b0;
               2'b10:   w_nxt = 1'b1;
               2'b11:   w_nxt = w_sr11;
               default: w_nxt = r_q;
             endcase
      default: case ({i_a, i_b})
               2'b01:   w_nxt = 1'b0;
               2'b10:   w_nxt = 1'b1;
               2'b11:   w_nxt = ~r_q;
               default: w_nxt = r_q;
             endcase
    endcase
  end

  // qn is its own flop loaded with the complement so it never skews from q.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q  <= RESET_BIT;
      r_qn <= ~RESET_BIT;
    end else if (i_en) begin
      r_q  <= w_nxt;
      r_qn <= ~w_nxt;
    end
  end

  assign o_q  = r_q;
  assign o_qn = r_qn;
endmodule

module multimode_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SR_POLICY = 0,
  parameter int               CNT_W     = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qn,
  output logic             o_illegal,
  output logic             o_illegal_sticky,
  output logic [CNT_W-1:0] o_illegal_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             w_event;
  logic             r_illegal, r_sticky;
  logic [CNT_W-1:0] r_cnt;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_lane
      multimode_ff_lane #(
        .SR_POLICY (SR_POLICY),
        .RESET_BIT (RESET_VAL[g])
      ) u_lane (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_en),
        .i_mode  (i_mode),
        .i_a     (i_a[g]),
        .i_b     (i_b[g]),
        .o_q     (o_q[g]),
        .o_qn    (o_qn[g])
      );
    end
  endgenerate

  // One event per cycle no matter how many channels collide.
  assign w_event = i_en & (i_mode == 2'b10) & (|(i_a & i_b));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_illegal <= 1'b0;
      r_sticky  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_illegal <= w_event;
      if (w_event) begin
        r_sticky <= 1'b1;
        if (i_clr_err)             r_cnt <= CNT_W'(1);
        else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      end else if (i_clr_err) begin
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  assign o_illegal        = r_illegal;
  assign o_illegal_sticky = r_sticky;
  assign o_illegal_cnt    = r_cnt;
endmodule

// File: tb/tb_multimode_ff_bank.sv
// Drives three banks (SR_POLICY 0/1/2, the policy-1 bank with CNT_W=2) from
// shared stimulus; a behavioural model pushes expectations into a queue.

module tb_multimode_ff_bank;
  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [1:0] mode;
  logic [7:0] a, b;

  logic [2:0][7:0] q, qn;
  logic [2:0]      ill, sticky;
  logic [3:0]      cnt0, cnt2;
  logic [1:0]      cnt1;

  always #5 clk = ~clk;

  multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR_POLICY(0), .CNT_W(4)) u_p0 (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_mode(mode), .i_a(a), .i_b(b),
    .i_clr_err(clr), .o_q(q[0]), .o_qn(qn[0]), .o_illegal(ill[0]),
    .o_illegal_sticky(sticky[0]), .o_illegal_cnt(cnt0));
  multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR_POLICY(1), .CNT_W(2)) u_p1 (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_mode(mode), .i_a(a), .i_b(b),
    .i_clr_err(clr), .o_q(q[1]), .o_qn(qn[1]), .o_illegal(ill[1]),
    .o_illegal_sticky(sticky[1]), .o_illegal_cnt(cnt1));
  multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR_POLICY(2), .CNT_W(4)) u_p2 (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_mode(mode), .i_a(a), .i_b(b),
    .i_clr_err(clr), .o_q(q[2]), .o_qn(qn[2]), .o_illegal(ill[2]),
    .o_illegal_sticky(sticky[2]), .o_illegal_cnt(cnt2));

  typedef struct packed {
    logic [2:0][7:0] q;
    logic [2:0]      ill;
    logic [2:0]      sticky;
    logic [2:0][3:0] cnt;
  } exp_t;

  exp_t     sb[$];
  int       ncmp = 0, nfail = 0;
  logic [7:0] mq[3];
  logic       mill[3], mst[3];
  int         mcnt[3];
  int         cmax[3] = '{15, 3, 15};

  task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[p%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_next(input int pol, input logic [1:0] m,
                                            input logic [7:0] cq, input logic [7:0] ia,
                                            input logic [7:0] ib);
    logic [7:0] both;
    both = ia & ib;
    case (m)
      2'b00: return ia;
      2'b01: return cq ^ ia;
      2'b10: return (cq & ~ia & ~ib) | (ia & ~ib) |
                    ((pol == 0) ? (cq & both) : (pol == 2) ? both : 8'h00);
      default: return (cq & ~ia & ~ib) | (ia & ~ib) | (~cq & both);
    endcase
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] ia, input logic [7:0] ib, input logic c);
    exp_t x, got;
    logic ev;
    rst = r; en = e; mode = m; a = ia; b = ib; clr = c;
    ev = e && (m == 2'b10) && ((ia & ib) != 8'h00);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        mq[k] = 8'hA5; mill[k] = 1'b0; mst[k] = 1'b0; mcnt[k] = 0;
      end else begin
        if (e) mq[k] = model_next(k, m, mq[k], ia, ib);
        mill[k] = ev;
        if (ev) begin
          mst[k]  = 1'b1;
          mcnt[k] = c ? 1 : ((mcnt[k] < cmax[k]) ? mcnt[k] + 1 : mcnt[k]);
        end else if (c) begin
          mst[k] = 1'b0; mcnt[k] = 0;
        end
      end
      x.q[k] = mq[k]; x.ill[k] = mill[k]; x.sticky[k] = mst[k]; x.cnt[k] = 4'(mcnt[k]);
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      check("q", k, q[k], got.q[k]);
      check("qn", k, qn[k], ~got.q[k]);
      check("illegal", k, {7'd0, ill[k]}, {7'd0, got.ill[k]});
      check("sticky", k, {7'd0, sticky[k]}, {7'd0, got.sticky[k]});
    end
    check("cnt", 0, {4'd0, cnt0}, {4'd0, got.cnt[0]});
    check("cnt", 1, {6'd0, cnt1}, {4'd0, got.cnt[1]});
    check("cnt", 2, {4'd0, cnt2}, {4'd0, got.cnt[2]});
  endtask

  localparam logic [1:0] MD = 2'b00, MT = 2'b01, MSR = 2'b10, MJK = 2'b11;

  initial begin
    rst = 1'b1; en = 1'b1; mode = MSR; a = 8'hFF; b = 8'hFF; clr = 1'b0;
    // Reset for two cycles with junk inputs, then hold with en=0.
    step(1, 1, MSR, 8'hFF, 8'hFF, 1);
    step(1, 1, MD,  8'h12, 8'h00, 0);
    step(0, 0, MD,  8'h3C, 8'h00, 0);
    // D then toggle twice.
    step(0, 1, MD, 8'h3C, 8'h00, 0);
    step(0, 1, MT, 8'hFF, 8'h00, 0);
    step(0, 1, MT, 8'hFF, 8'h00, 0);
    // SR 11 resolution per policy, then observe the pulse while holding.
    step(0, 1, MD,  8'h0F, 8'h00, 0);
    step(0, 1, MSR, 8'hFF, 8'hFF, 0);
    step(0, 0, MSR, 8'hFF, 8'hFF, 0);
    step(0, 1, MSR, 8'h30, 8'h03, 0);
    // JK: toggle, set/reset, clear; never illegal.
    step(0, 1, MD,  8'h0F, 8'h00, 0);
    step(0, 1, MJK, 8'hFF, 8'hFF, 0);
    step(0, 1, MJK, 8'hF0, 8'h0F, 0);
    step(0, 1, MJK, 8'h00, 8'hFF, 0);
    // Saturation of the 2-bit counter and clear interactions.
    step(0, 1, MSR, 8'h00, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(0, 1, MSR, 8'h01, 8'h01, 0);
    step(0, 1, MSR, 8'h80, 8'h80, 1);
    step(0, 1, MD,  8'h55, 8'h00, 1);
    step(0, 1, MSR, 8'h02, 8'h02, 0);
    // Reset wins over an illegal event and clear on the same edge.
    step(1, 1, MSR, 8'hFF, 8'hFF, 1);
    step(0, 1, MT,  8'h0F, 8'h00, 0);
    // Mixed random traffic.
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 7) == 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
